game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Synthesizable initiator for the Game_State counter-game block.
- Drives Game_State's reset, control, i_value and INIT, and consumes its who, los, win and gameover outputs.
- On start, sweeps all 16 scenarios (4 control modes x 4 init values), runs each until gameover or timeout, and reports per-scenario results plus aggregate win/loss/timeout counts.
- Sits beside Game_State in the game subsystem and replaces manual stimulus for bring-up and self-test.

Parameters:
- COUNTER_SIZE, 4, width of i_value; must match Game_State.
- RST_CYC, 2, cycles g_reset is held high before each scenario (>=1).
- TIMEOUT_CYC, 1023, maximum RUN cycles per scenario before it is declared a timeout (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_l  in  1  reset; one clock, asynchronous and active-low.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- abort  in  1  cancel sweep; return to IDLE.
- g_reset  out  1  to Game_State reset; 1 holds the game in reset.
- control  out  2  to Game_State control; equals scen_idx[3:2].
- i_value  out  COUNTER_SIZE  to Game_State i_value; table indexed by scen_idx[1:0]: 0, 1, 2, 2^COUNTER_SIZE-1.
- INIT  out  1  to Game_State INIT.
- who  in  2  from Game_State; 2'b10 means winner, any other value means loser.
- los, win  in  1 each  from Game_State; observed only, never used for decisions.
- gameover  in  1  from Game_State.
- busy  out  1  high while a sweep is active.
- done  out  1  high in DONE until the next start.
- scen_idx  out  4  current scenario index.
- res_valid  out  1  one-cycle pulse when a scenario completes.
- res_code  out  2  result of that scenario: 00 loser, 01 winner, 10 timeout. Valid with res_valid; held otherwise.
- win_cnt, los_cnt, tmo_cnt  out  5 each  per-sweep result counters.

Behaviour:
- Reset (rst_l=0, asynchronous): g_reset=1, control=0, i_value=0, INIT=0, busy=0, done=0, scen_idx=0, res_valid=0, res_code=00, all counters 0, state=IDLE, timer=0, gameover_q=0.
- control and i_value are combinational from scen_idx and stay stable for the whole scenario, including during g_reset.
- gameover_q registers gameover every cycle in every state. A gameover edge is gameover & ~gameover_q and is acted on only in RUN.
- IDLE: g_reset=1, busy=0. On start: clear the three counters and scen_idx, then go to RST.
- RST: g_reset=1, busy=1; lasts RST_CYC cycles, then LOAD.
- LOAD: g_reset=0, INIT=1 for exactly 2 cycles, then RUN with timer=0.
- RUN: g_reset=0, INIT=0, timer increments each cycle.
  - On a gameover edge: res_code = (who==2'b10) ? 01 : 00; go to REPORT.
  - Otherwise, when timer==TIMEOUT_CYC-1: res_code=10; go to REPORT.
  - A gameover edge in the same cycle as the timeout takes priority; the result is win or loss, not timeout.
  - gameover already high when RUN is entered is not an edge; that scenario ends in timeout.
- REPORT: lasts 1 cycle. res_valid=1, the matching counter increments, g_reset=1.
  - If scen_idx==15: go to DONE.
  - Otherwise: scen_idx+1, go to RST.
- DONE: done=1, busy=0, g_reset=1; counters and scen_idx are held. On start: behave as IDLE+start.
- abort=1 in RST, LOAD, RUN or REPORT: next state IDLE, g_reset=1, INIT=0, scen_idx=0, counters held. An abort during REPORT still lets that pulse and its counter update complete. abort is ignored in IDLE and DONE.
- start outside IDLE and DONE is ignored.
- Counters cannot overflow; maximum is 16 in 5 bits. win_cnt+los_cnt+tmo_cnt == 16 at DONE.
- Latency: start sampled at edge k -> g_reset high from k+1 to k+RST_CYC, INIT high for the next 2 cycles, RUN starts at k+RST_CYC+3.

Test Plan:
- rst_l driven low mid-RUN in scenario 5 -> every output takes its reset value immediately, without waiting for a clock edge. After release, the block idles with g_reset=1.
- Stub raises gameover with who=2'b10 10 cycles into every RUN; pulse start -> 16 res_valid pulses with res_code=01; win_cnt=16, los_cnt=tmo_cnt=0; done=1. At scen_idx=7: control=1, i_value=15.
- Stub never raises gameover, TIMEOUT_CYC=8 -> each RUN lasts exactly 8 cycles; res_code=10 every scenario; tmo_cnt=16 at DONE.
- Stub raises gameover with who=2'b01 exactly on the timeout cycle -> res_code=00, los_cnt increments, tmo_cnt is unchanged.
- abort during RUN of scenario 3 -> next cycle state IDLE, busy=0, g_reset=1, scen_idx=0, counters keep their values. A later start clears the counters and restarts at scenario 0.
- start at cycle 0 with RST_CYC=2 -> g_reset=1 on cycles 1-2, INIT=1 on cycles 3-4, RUN from cycle 5. start held high during RUN has no effect.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: drives the Game_State counter game through all 16
// scenarios (4 control modes x 4 init values). Each scenario is run until
// gameover or timeout. Per-scenario results and per-sweep totals are reported.
module game_sequencer #(
  parameter int COUNTER_SIZE = 4,
  parameter int RST_CYC      = 2,
  parameter int TIMEOUT_CYC  = 1023
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    start,
  input  logic                    abort,
  output logic                    g_reset,
  output logic [1:0]              control,
  output logic [COUNTER_SIZE-1:0] i_value,
  output logic                    INIT,
  input  logic [1:0]              who,
  input  logic                    los,
  input  logic                    win,
  input  logic                    gameover,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              scen_idx,
  output logic                    res_valid,
  output logic [1:0]              res_code,
  output logic [4:0]              win_cnt,
  output logic [4:0]              los_cnt,
  output logic [4:0]              tmo_cnt
);

  // One counter serves as the phase timer for RST, LOAD and RUN, so it must
  // be wide enough for the longer of the two limits.
  localparam int TMAX = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] RUN_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] LOAD_LAST = TW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          gameover_q;
  logic          go_edge;
  logic          in_sweep;

  // The win and los flags from the game are observed only. They do not drive any decision.
  logic          unused_obs;
  assign unused_obs = los ^ win;

  assign go_edge  = gameover & ~gameover_q;
  assign in_sweep = (state == RST) || (state == LOAD) ||
                    (state == RUN) || (state == REPORT);

  // The game inputs depend only on the scenario index. They hold steady for the whole scenario.
  assign control = scen_idx[3:2];
  always_comb begin
    i_value = '0;
    case (scen_idx[1:0])
      2'd0:    i_value = '0;
      2'd1:    i_value = COUNTER_SIZE'(1);
      2'd2:    i_value = COUNTER_SIZE'(2);
      default: i_value = '1;
    endcase
  end

  // Delayed gameover used for edge detection, sampled in every state
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) gameover_q <= 1'b0;
    else        gameover_q <= gameover;
  end

  // Sweep sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      timer     <= '0;
      g_reset   <= 1'b1;
      INIT      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      scen_idx  <= '0;
      res_valid <= 1'b0;
      res_code  <= 2'b00;
      win_cnt   <= '0;
      los_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      res_valid <= 1'b0;
      if (abort && in_sweep) begin
        // REPORT already issued its pulse and counter update on entry
        state    <= IDLE;
        timer    <= '0;
        g_reset  <= 1'b1;
        INIT     <= 1'b0;
        busy     <= 1'b0;
        scen_idx <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state    <= RST;
              timer    <= '0;
              g_reset  <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
              scen_idx <= '0;
              win_cnt  <= '0;
              los_cnt  <= '0;
              tmo_cnt  <= '0;
            end
          end
          RST: begin
            if (timer == RST_LAST) begin
              state   <= LOAD;
              timer   <= '0;
              g_reset <= 1'b0;
              INIT    <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          LOAD: begin
            if (timer == LOAD_LAST) begin
              state <= RUN;
              timer <= '0;
              INIT  <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          RUN: begin
            // A gameover edge wins over a timeout that falls in the same cycle.
            if (go_edge) begin
              state     <= REPORT;
              g_reset   <= 1'b1;
              res_valid <= 1'b1;
              if (who == 2'b10) begin
                res_code <= 2'b01;
                win_cnt  <= win_cnt + 5'd1;
              end else begin
                res_code <= 2'b00;
                los_cnt  <= los_cnt + 5'd1;
              end
            end else if (timer == RUN_LAST) begin
              state     <= REPORT;
              g_reset   <= 1'b1;
              res_valid <= 1'b1;
              res_code  <= 2'b10;
              tmo_cnt   <= tmo_cnt + 5'd1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          REPORT: begin
            timer <= '0;
            if (scen_idx == 4'd15) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= RST;
              scen_idx <= scen_idx + 4'd1;
            end
          end
          default: begin
            state   <= IDLE;
            g_reset <= 1'b1;
            INIT    <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed sweeps against a behavioural Game_State stub.
// A scoreboard queue holds the expected per-scenario results.
module tb_game_sequencer;

  localparam int CS  = 4;
  localparam int TMO = 12;
  localparam int RC  = 2;

  // Stub behaviours
  localparam int M_NONE  = 0;  // gameover never rises
  localparam int M_WIN   = 1;  // gameover with who=10 at RUN cycle 10
  localparam int M_LOSE  = 2;  // gameover with who=01 on the timeout cycle
  localparam int M_STUCK = 3;  // gameover stuck high

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          g_reset;
  logic [1:0]    control;
  logic [CS-1:0] i_value;
  logic          INIT;
  logic [1:0]    who;
  logic          los, win, gameover;
  logic          busy, done, res_valid;
  logic [3:0]    scen_idx;
  logic [1:0]    res_code;
  logic [4:0]    win_cnt, los_cnt, tmo_cnt;

  int tests = 0;
  int fails = 0;
  int mode  = M_NONE;
  logic [7:0] run_cyc = 8'd0;

  typedef struct {
    logic [3:0] scen;
    logic [1:0] code;
  } exp_t;
  exp_t sb_q[$];

  game_sequencer #(.COUNTER_SIZE(CS), .RST_CYC(RC), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .abort(abort),
    .g_reset(g_reset), .control(control), .i_value(i_value), .INIT(INIT),
    .who(who), .los(los), .win(win), .gameover(gameover),
    .busy(busy), .done(done), .scen_idx(scen_idx), .res_valid(res_valid),
    .res_code(res_code), .win_cnt(win_cnt), .los_cnt(los_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  // Stub: counts cycles since the game left reset/INIT
  always @(posedge clk) begin
    if (g_reset || INIT) run_cyc <= 8'd0;
    else if (run_cyc != 8'hff) run_cyc <= run_cyc + 8'd1;
  end

  assign gameover = (mode == M_STUCK) ||
                    (!g_reset && !INIT &&
                     ((mode == M_WIN  && run_cyc >= 8'd10) ||
                      (mode == M_LOSE && run_cyc >= 8'(TMO - 1))));
  assign who = (mode == M_WIN) ? 2'b10 : (mode == M_LOSE) ? 2'b01 : 2'b00;
  assign win = gameover && (who == 2'b10);
  assign los = gameover && (who != 2'b10);

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ival_of(input logic [3:0] s);
    case (s[1:0])
      2'd0:    return 0;
      2'd1:    return 1;
      2'd2:    return 2;
      default: return (1 << CS) - 1;
    endcase
  endfunction

  task automatic push_sweep(input int n, input logic [1:0] code);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.scen = 4'(i);
      e.code = code;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: compare each result pulse against the scoreboard
  always @(negedge clk) begin
    if (rst_l && res_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_code", int'(res_code), int'(e.code));
        check("res_scen", int'(scen_idx), int'(e.scen));
        check("res_control", int'(control), int'(e.scen[3:2]));
        check("res_i_value", int'(i_value), ival_of(e.scen));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check(name, int'(done), 1);
    check({name, "_drained"}, sb_q.size(), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic wait_run(input int s);
    int c = 0;
    while (!(scen_idx == 4'(s) && busy && !g_reset && !INIT) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("reach_run", (c < 1000) ? 1 : 0, 1);
  endtask

  task automatic check_counts(input string name, input int w, input int l, input int t);
    check({name, "_win_cnt"}, int'(win_cnt), w);
    check({name, "_los_cnt"}, int'(los_cnt), l);
    check({name, "_tmo_cnt"}, int'(tmo_cnt), t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_g[5];
    int exp_i[5];
    exp_g = '{1, 1, 0, 0, 0};
    exp_i = '{0, 0, 1, 1, 0};

    // Reset values
    #12;
    check("rst_g_reset", int'(g_reset), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_init", int'(INIT), 0);
    check("rst_scen", int'(scen_idx), 0);
    check("rst_code", int'(res_code), 0);
    check_counts("rst", 0, 0, 0);
    @(negedge clk) rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // Win sweep with startup latency; start held through early RUN
    mode = M_WIN;
    push_sweep(16, 2'b01);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lat_g_reset", int'(g_reset), exp_g[i]);
      check("lat_init", int'(INIT), exp_i[i]);
      check("lat_busy", int'(busy), 1);
    end
    repeat (3) @(negedge clk);
    check("start_in_run_scen", int'(scen_idx), 0);
    check("start_in_run_g", int'(g_reset), 0);
    start = 1'b0;
    wait_done("win_sweep");
    check_counts("win", 16, 0, 0);

    // Timeout sweep, restarted from DONE
    mode = M_NONE;
    push_sweep(16, 2'b10);
    pulse_start();
    check("restart_done_low", int'(done), 0);
    check_counts("restart", 0, 0, 0);
    wait_done("tmo_sweep");
    check_counts("tmo", 0, 0, 16);

    // Gameover on the timeout cycle is a loss, not a timeout
    mode = M_LOSE;
    push_sweep(16, 2'b00);
    pulse_start();
    wait_done("lose_sweep");
    check_counts("lose", 0, 16, 0);

    // Gameover already high on entering RUN is not an edge
    mode = M_STUCK;
    push_sweep(16, 2'b10);
    pulse_start();
    wait_done("stuck_sweep");
    check_counts("stuck", 0, 0, 16);

    // Abort during RUN of scenario 3
    mode = M_NONE;
    push_sweep(3, 2'b10);
    pulse_start();
    check_counts("abort_clear", 0, 0, 0);
    wait_run(3);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_g_reset", int'(g_reset), 1);
    check("abort_init", int'(INIT), 0);
    check("abort_scen", int'(scen_idx), 0);
    check("abort_done", int'(done), 0);
    check("abort_drained", sb_q.size(), 0);
    check_counts("abort", 0, 0, 3);
    repeat (3) @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    check_counts("abort_held", 0, 0, 3);

    // Restart after abort begins again at scenario 0 with cleared counters
    mode = M_WIN;
    push_sweep(16, 2'b01);
    pulse_start();
    check("post_abort_scen", int'(scen_idx), 0);
    check("post_abort_busy", int'(busy), 1);
    check_counts("post_abort", 0, 0, 0);
    wait_done("post_abort_sweep");
    check_counts("post_abort_end", 16, 0, 0);

    // Asynchronous reset in the middle of RUN of scenario 5
    push_sweep(5, 2'b01);
    pulse_start();
    wait_run(5);
    repeat (2) @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    check("arst_g_reset", int'(g_reset), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_init", int'(INIT), 0);
    check("arst_scen", int'(scen_idx), 0);
    check("arst_control", int'(control), 0);
    check("arst_i_value", int'(i_value), 0);
    check("arst_res_valid", int'(res_valid), 0);
    check("arst_code", int'(res_code), 0);
    check_counts("arst", 0, 0, 0);
    @(negedge clk) rst_l = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_idle_g_reset", int'(g_reset), 1);
    check("arst_idle_busy", int'(busy), 0);
    check("arst_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
